// File: rtl/execute_cycle_mc.sv
// execute_cycle_mc: execute stage with operand forwarding, ALU, branch
// resolution, an iterative unsigned divider and the EX/MEM pipeline register.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   valid_E, flush_E         EX instruction valid / kill from the hazard unit
//   RegWriteE..ALUSrcE       decoded single-bit controls
//   ALUControlE              ALU op (add, sub, mul, divu, remu, and, or, slt)
//   RD1_E, RD2_E, Imm_Ext_E  register operands and extended immediate
//   RD_E                     destination register index
//   PCE, PCPlus4E            PC and PC+4 of the EX instruction
//   ResultW                  write-back value for forwarding
//   ForwardA_E, ForwardB_E   forwarding selects
//   StallE                   holds IF/ID/EX inputs while the divider runs (comb)
//   PCSrcE, PCTargetE        branch taken / branch target (comb)
//   RegWriteM..DivByZeroM    EX/MEM register outputs
module execute_cycle_mc #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_E,
  input  logic                  flush_E,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic [DATA_W-1:0]     RD1_E,
  input  logic [DATA_W-1:0]     RD2_E,
  input  logic [DATA_W-1:0]     Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [DATA_W-1:0]     PCE,
  input  logic [DATA_W-1:0]     PCPlus4E,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  output logic                  StallE,
  output logic                  PCSrcE,
  output logic [DATA_W-1:0]     PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_W-1:0]     PCPlus4M,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [DATA_W-1:0]     ALU_ResultM,
  output logic                  DivByZeroM
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  div_state_t div_state, div_state_nxt;

  logic [DATA_W-1:0] src_a, fwd_b, src_b;
  logic [DATA_W-1:0] alu_res, mul_lo;
  logic              is_div, src_b_zero, alu_zero;
  logic              div_stall, div_start, div_step, m_bubble;

  logic [DATA_W-1:0] div_rem, div_quo, div_den;
  logic              div_is_rem;
  logic [CNT_W-1:0]  div_cnt;
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic [DATA_W-1:0] div_res;

  // Operand forwarding muxes
  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b      = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign is_div     = (ALUControlE == OP_DIVU) || (ALUControlE == OP_REMU);
  assign src_b_zero = (src_b == '0);
  assign mul_lo     = src_a * src_b;

  // Single-cycle ALU; divide ops yield their divide-by-zero value here
  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_MUL:  alu_res = mul_lo;
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = src_a;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = DATA_W'($signed(src_a) < $signed(src_b));
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Divider FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_state <= DIV_IDLE;
    else      div_state <= div_state_nxt;
  end

  // Divider FSM: next state and stall; start is gated by rst so StallE
  // reads 0 while reset is asserted
  always_comb begin
    div_state_nxt = div_state;
    div_stall     = 1'b0;
    div_start     = 1'b0;
    div_step      = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (rst && valid_E && !flush_E && is_div && !src_b_zero) begin
          div_stall     = 1'b1;
          div_start     = 1'b1;
          div_state_nxt = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (flush_E) begin
          div_state_nxt = DIV_IDLE;
        end else begin
          div_stall = 1'b1;
          div_step  = 1'b1;
          if (div_cnt == CNT_W'(DATA_W - 1)) div_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: div_state_nxt = DIV_IDLE;
      default:  div_state_nxt = DIV_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign rem_sh   = {div_rem, div_quo[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, div_den};
  assign div_res  = div_is_rem ? div_rem : div_quo;

  // Divider datapath; operands are captured so later forwarding changes don't matter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_rem    <= '0;
      div_quo    <= '0;
      div_den    <= '0;
      div_is_rem <= 1'b0;
      div_cnt    <= '0;
    end else if (div_start) begin
      div_rem    <= '0;
      div_quo    <= src_a;
      div_den    <= src_b;
      div_is_rem <= (ALUControlE == OP_REMU);
      div_cnt    <= '0;
    end else if (div_step) begin
      div_rem    <= rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
      div_quo    <= {div_quo[DATA_W-2:0], ~rem_diff[DATA_W]};
      div_cnt    <= div_cnt + CNT_W'(1);
    end
  end

  assign StallE    = div_stall;
  assign m_bubble  = flush_E || !valid_E || div_stall;
  assign PCSrcE    = valid_E && BranchE && alu_zero && !flush_E && !div_stall;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM register; bubbles clear controls and hold data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      DivByZeroM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (m_bubble) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      DivByZeroM  <= 1'b0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= (div_state == DIV_DONE) ? div_res : alu_res;
      DivByZeroM  <= (div_state == DIV_IDLE) && is_div && src_b_zero;
    end
  end

endmodule

// File: tb/tb_execute_cycle_mc.sv
// Bench for execute_cycle_mc: a 24-bit and a 16-bit instance share one
// stimulus stream; a transaction-level model predicts both every cycle.
module tb_execute_cycle_mc;

  logic clk = 1'b0;
  logic rst;
  logic valid, flush, rw, mw, rs, br, alusrc;
  logic [2:0]  op;
  logic [31:0] rd1, rd2, imm, pce, pc4, resw;
  logic [4:0]  rd;
  logic [1:0]  fa, fb;

  always #5 clk = ~clk;

  logic        stall24, pcsrc24, rw24, mw24, rs24, dz24;
  logic [23:0] pct24, pc4_24, wd24, alu24;
  logic [4:0]  rd24;
  logic        stall16, pcsrc16, rw16, mw16, rs16, dz16;
  logic [15:0] pct16, pc4_16, wd16, alu16;
  logic [4:0]  rd16;

  execute_cycle_mc #(.DATA_W(24), .REG_ADDR_W(5)) u24 (
    .clk(clk), .rst(rst), .valid_E(valid), .flush_E(flush),
    .RegWriteE(rw), .MemWriteE(mw), .ResultSrcE(rs), .BranchE(br), .ALUSrcE(alusrc),
    .ALUControlE(op), .RD1_E(rd1[23:0]), .RD2_E(rd2[23:0]), .Imm_Ext_E(imm[23:0]),
    .RD_E(rd), .PCE(pce[23:0]), .PCPlus4E(pc4[23:0]), .ResultW(resw[23:0]),
    .ForwardA_E(fa), .ForwardB_E(fb),
    .StallE(stall24), .PCSrcE(pcsrc24), .PCTargetE(pct24),
    .RegWriteM(rw24), .MemWriteM(mw24), .ResultSrcM(rs24), .RD_M(rd24),
    .PCPlus4M(pc4_24), .WriteDataM(wd24), .ALU_ResultM(alu24), .DivByZeroM(dz24)
  );

  execute_cycle_mc #(.DATA_W(16), .REG_ADDR_W(5)) u16 (
    .clk(clk), .rst(rst), .valid_E(valid), .flush_E(flush),
    .RegWriteE(rw), .MemWriteE(mw), .ResultSrcE(rs), .BranchE(br), .ALUSrcE(alusrc),
    .ALUControlE(op), .RD1_E(rd1[15:0]), .RD2_E(rd2[15:0]), .Imm_Ext_E(imm[15:0]),
    .RD_E(rd), .PCE(pce[15:0]), .PCPlus4E(pc4[15:0]), .ResultW(resw[15:0]),
    .ForwardA_E(fa), .ForwardB_E(fb),
    .StallE(stall16), .PCSrcE(pcsrc16), .PCTargetE(pct16),
    .RegWriteM(rw16), .MemWriteM(mw16), .ResultSrcM(rs16), .RD_M(rd16),
    .PCPlus4M(pc4_16), .WriteDataM(wd16), .ALU_ResultM(alu16), .DivByZeroM(dz16)
  );

  // Instance 0 = 24-bit, instance 1 = 16-bit
  logic        o_stall [2], o_pcsrc [2], o_rw [2], o_mw [2], o_rs [2], o_dz [2];
  logic [31:0] o_pct [2], o_pc4 [2], o_wd [2], o_alu [2];
  logic [4:0]  o_rd [2];
  assign o_stall[0] = stall24;  assign o_stall[1] = stall16;
  assign o_pcsrc[0] = pcsrc24;  assign o_pcsrc[1] = pcsrc16;
  assign o_rw[0]    = rw24;     assign o_rw[1]    = rw16;
  assign o_mw[0]    = mw24;     assign o_mw[1]    = mw16;
  assign o_rs[0]    = rs24;     assign o_rs[1]    = rs16;
  assign o_dz[0]    = dz24;     assign o_dz[1]    = dz16;
  assign o_rd[0]    = rd24;     assign o_rd[1]    = rd16;
  assign o_pct[0]   = 32'(pct24);  assign o_pct[1] = 32'(pct16);
  assign o_pc4[0]   = 32'(pc4_24); assign o_pc4[1] = 32'(pc4_16);
  assign o_wd[0]    = 32'(wd24);   assign o_wd[1]  = 32'(wd16);
  assign o_alu[0]   = 32'(alu24);  assign o_alu[1] = 32'(alu16);

  int checks = 0;
  int errors = 0;

  // Model state: expected EX/MEM contents and an in-flight divide
  logic        m_rw [2], m_mw [2], m_rs [2], m_dz [2];
  logic [4:0]  m_rd [2];
  logic [31:0] m_pc4 [2], m_wd [2], m_alu [2];
  bit          d_act [2], d_rem [2];
  int          d_k [2];
  logic [31:0] d_q [2], d_r [2];
  // Combinational outputs seen in the most recent cycle
  logic        s_stall [2], s_pcsrc [2];
  logic [31:0] s_pct [2];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h exp %0h", nm, i, got, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 24 : 16;
  endfunction

  function automatic longint sx(input logic [31:0] x, input int w);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r, input int i);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return m_alu[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rw[i] = 0; m_mw[i] = 0; m_rs[i] = 0; m_dz[i] = 0; m_rd[i] = '0;
      m_pc4[i] = '0; m_wd[i] = '0; m_alu[i] = '0;
      d_act[i] = 0; d_rem[i] = 0; d_k[i] = 0; d_q[i] = '0; d_r[i] = '0;
    end
  endtask

  // Compare one instance against the model for this cycle, then advance the model
  task automatic model_cycle(input int i);
    int w;
    logic [31:0] mk, a, fbv, b, single;
    bit isdiv, st, pcs, bub;
    w  = wid(i);
    mk = (32'd1 << w) - 32'd1;
    a   = fwd(fa, rd1, i) & mk;
    fbv = fwd(fb, rd2, i) & mk;
    b   = alusrc ? (imm & mk) : fbv;
    isdiv = (op == 3'd3) || (op == 3'd4);
    case (op)
      3'd0: single = a + b;
      3'd1: single = a - b;
      3'd2: single = a * b;
      3'd3: single = mk;
      3'd4: single = a;
      3'd5: single = a & b;
      3'd6: single = a | b;
      default: single = (sx(a, w) < sx(b, w)) ? 32'd1 : 32'd0;
    endcase
    single &= mk;
    if (!d_act[i]) st = valid && !flush && isdiv && (b != 0);
    else           st = !flush && (d_k[i] <= w);
    pcs = valid && br && (single == 0) && !flush && !st;

    s_stall[i] = o_stall[i];
    s_pcsrc[i] = o_pcsrc[i];
    s_pct[i]   = o_pct[i];
    chk("StallE", i, 32'(o_stall[i]), 32'(st));
    chk("PCSrcE", i, 32'(o_pcsrc[i]), 32'(pcs));
    chk("PCTargetE", i, o_pct[i], (pce + imm) & mk);
    chk("RegWriteM", i, 32'(o_rw[i]), 32'(m_rw[i]));
    chk("MemWriteM", i, 32'(o_mw[i]), 32'(m_mw[i]));
    chk("ResultSrcM", i, 32'(o_rs[i]), 32'(m_rs[i]));
    chk("DivByZeroM", i, 32'(o_dz[i]), 32'(m_dz[i]));
    chk("RD_M", i, 32'(o_rd[i]), 32'(m_rd[i]));
    chk("PCPlus4M", i, o_pc4[i], m_pc4[i]);
    chk("WriteDataM", i, o_wd[i], m_wd[i]);
    chk("ALU_ResultM", i, o_alu[i], m_alu[i]);

    bub = flush || !valid || st;
    if (bub) begin
      m_rw[i] = 0; m_mw[i] = 0; m_rs[i] = 0; m_dz[i] = 0;
    end else begin
      m_rw[i] = rw; m_mw[i] = mw; m_rs[i] = rs; m_rd[i] = rd;
      m_pc4[i] = pc4 & mk; m_wd[i] = fbv;
      m_alu[i] = d_act[i] ? (d_rem[i] ? d_r[i] : d_q[i]) : single;
      m_dz[i]  = !d_act[i] && isdiv && (b == 0);
    end
    if (d_act[i]) begin
      if (flush || d_k[i] == w + 1) d_act[i] = 0;
      else d_k[i]++;
    end else if (st) begin
      d_act[i] = 1; d_k[i] = 1;
      d_q[i] = a / b; d_r[i] = a % b;
      d_rem[i] = (op == 3'd4);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_cycle(i);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = 1; flush = 0; rw = 1; mw = 0; rs = 0; br = 0; alusrc = 0; op = 3'd0;
    rd1 = 0; rd2 = 0; imm = 0; rd = 5'd3; pce = 32'h40; pc4 = 32'h44; resw = 0;
    fa = 2'b00; fb = 2'b00;
  endtask

  logic [2:0]  v_op  [6] = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd0, 3'd2};
  logic [31:0] v_a   [6] = '{32'hF0F0, 32'h0F00, 32'h0005, 32'h0003, 32'h1234, 32'h0007};
  logic [31:0] v_b   [6] = '{32'h3C3C, 32'h00F0, 32'h0009, 32'h0007, 32'h0011, 32'h0006};
  logic [1:0]  v_fb  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
  logic        v_src [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  int nstall;

  initial begin
    clr();
    valid = 0;
    rst = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset RegWriteM", 0, 32'(rw24), 32'd0);
    chk("reset ALU_ResultM", 0, 32'(alu24), 32'd0);
    chk("reset StallE", 0, 32'(stall24), 32'd0);
    rst = 1;

    // Forwarding paths on add
    clr(); rd1 = 10; rd2 = 5; tick();
    chk("add 10+5", 0, 32'(alu24), 32'd15);
    chk("add RegWriteM", 0, 32'(rw24), 32'd1);
    fa = 2'b01; resw = 50; tick();
    chk("add fwd ResultW", 0, 32'(alu24), 32'd55);
    fa = 2'b10; tick();
    chk("add fwd ALU_ResultM", 1, 32'(alu16), 32'd60);

    // divu 100/4: stall for W+1 cycles, result on the next edge
    clr(); op = 3'd3; rd1 = 100; rd2 = 4; nstall = 0;
    tick(); if (s_stall[0]) nstall++;
    chk("div bubble RegWriteM", 0, 32'(rw24), 32'd0);
    for (int c = 1; c < 26; c++) begin tick(); if (s_stall[0]) nstall++; end
    chk("divu stall cycles", 0, 32'(nstall), 32'd25);
    chk("divu 100/4", 0, 32'(alu24), 32'd25);
    flush = 1; tick();

    clr(); op = 3'd4; rd1 = 100; rd2 = 7;
    for (int c = 0; c < 26; c++) tick();
    chk("remu 100/7", 0, 32'(alu24), 32'd2);
    flush = 1; tick();

    // Divide by zero completes in one cycle
    clr(); op = 3'd3; rd1 = 9; rd2 = 0; tick();
    chk("div0 no stall", 0, 32'(s_stall[0]), 32'd0);
    chk("divu 9/0", 0, 32'(alu24), 32'hFFFFFF);
    chk("divu 9/0 16b", 1, 32'(alu16), 32'hFFFF);
    chk("divu 9/0 flag", 0, 32'(dz24), 32'd1);
    op = 3'd4; tick();
    chk("remu 9/0", 0, 32'(alu24), 32'd9);

    // Branch resolution
    clr(); op = 3'd1; rd1 = 10; rd2 = 10; br = 1; pce = 100; imm = 8; rw = 0; tick();
    chk("branch taken", 0, 32'(s_pcsrc[0]), 32'd1);
    chk("branch target", 0, s_pct[0], 32'd108);
    flush = 1; tick();
    chk("branch flushed", 0, 32'(s_pcsrc[0]), 32'd0);

    // Flush mid-division on stall cycle 5
    clr(); op = 3'd3; rd1 = 1000; rd2 = 3;
    for (int c = 0; c < 4; c++) tick();
    flush = 1; tick();
    chk("flush drops stall", 0, 32'(s_stall[0]), 32'd0);
    chk("flush bubble", 0, 32'(rw24), 32'd0);
    clr(); rd1 = 7; rd2 = 8; tick();
    chk("add after flush", 0, 32'(alu24), 32'd15);
    chk("add after flush rw", 0, 32'(rw24), 32'd1);

    // Reset on stall cycle 10
    clr(); op = 3'd3; rd1 = 1000; rd2 = 3;
    for (int c = 0; c < 9; c++) tick();
    rst = 0; #1;
    chk("rst StallE", 0, 32'(stall24), 32'd0);
    chk("rst ALU_ResultM", 0, 32'(alu24), 32'd0);
    chk("rst WriteDataM", 0, 32'(wd24), 32'd0);
    chk("rst PCPlus4M", 0, 32'(pc4_24), 32'd0);
    chk("rst RD_M", 0, 32'(rd24), 32'd0);
    chk("rst ALU_ResultM 16b", 1, 32'(alu16), 32'd0);
    @(posedge clk); #1;
    clr(); valid = 0; rst = 1; model_reset();
    tick();

    // Width-dependent wrap and sign
    clr(); rd1 = 32'hFFFF; rd2 = 1; tick();
    chk("add wrap 16b", 1, 32'(alu16), 32'd0);
    op = 3'd2; rd1 = 32'h100; rd2 = 32'h100; tick();
    chk("mul wrap 16b", 1, 32'(alu16), 32'd0);
    op = 3'd7; rd1 = 32'hFFFF; rd2 = 1; tick();
    chk("slt -1<1 16b", 1, 32'(alu16), 32'd1);

    // Mixed ops with immediate, store and forwarding selects
    for (int v = 0; v < 6; v++) begin
      clr(); op = v_op[v]; rd1 = v_a[v]; rd2 = v_b[v]; fb = v_fb[v];
      alusrc = v_src[v]; imm = 32'h20 + 32'(v); resw = 32'h77;
      mw = v[0]; rs = v[1]; rd = 5'(v + 10); br = 1; pc4 = 32'h200 + 32'(v);
      tick();
    end
    clr(); valid = 0; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_cycle_mc.md
Name: execute_cycle_mc

Overview:
Parametrised, multi-cycle-capable execute stage for the pipelined processor. It sits between the decode/EX and EX/MEM pipeline registers. It owns the operand forwarding muxes, the ALU, branch resolution and the EX/MEM register. Add, sub, logic, compare and multiply complete in one cycle. Unsigned divide and remainder use an iterative restoring divider that stalls the front of the pipeline through a StallE handshake.

Parameters:
DATA_W, 24, datapath width (operands, PC, results); legal range 8..32
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
valid_E  in  1  EX-stage instruction valid (0 = bubble)
flush_E  in  1  kill the EX instruction (from hazard unit)
RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls
ALUControlE  in  3  ALU op
RD1_E, RD2_E, Imm_Ext_E  in  DATA_W  register operands, extended immediate
RD_E  in  REG_ADDR_W  destination register
PCE, PCPlus4E  in  DATA_W  PC, PC+4
ResultW  in  DATA_W  WB forward value
ForwardA_E, ForwardB_E  in  2  00 = RDx_E, 01 = ResultW, 10 = ALU_ResultM, 11 = RDx_E
StallE  out  1  hold IF/ID/EX inputs stable
PCSrcE  out  1  branch taken
PCTargetE  out  DATA_W  PCE + Imm_Ext_E (mod 2^DATA_W)
RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls
RD_M  out  REG_ADDR_W;  PCPlus4M, WriteDataM, ALU_ResultM  out  DATA_W  registered
DivByZeroM  out  1  registered divide-by-zero flag

Behaviour:
- Reset (rst=0, async): all M outputs 0, divider state IDLE, counter 0, StallE=0. Reset mid-division aborts silently.
- Operands:
  - SrcA = ForwardA mux.
  - SrcB = ALUSrcE ? Imm_Ext_E : ForwardB mux.
  - WriteData = ForwardB mux output.
- ALU ops; all arithmetic wraps mod 2^DATA_W, no overflow output:
  - 000 add
  - 001 sub
  - 010 mul (low DATA_W bits of the product)
  - 011 divu (quotient)
  - 100 remu
  - 101 and
  - 110 or
  - 111 slt (signed, result 0/1)
- Zero = (single-cycle result == 0).
- PCSrcE = valid_E & BranchE & Zero & ~flush_E & ~StallE. Combinational.
- Single-cycle ops: EX/MEM register loads at the next edge (latency 1).
- Divider FSM (op 011/100, valid_E=1, flush_E=0):
  - IDLE: if SrcB==0, complete in 1 cycle with no stall. Quotient = all ones, remainder = SrcA, DivByZeroM=1. Otherwise StallE=1 combinationally. Latch SrcA, SrcB and op at the edge, go to BUSY with count=0.
  - BUSY: one restoring step per cycle, StallE=1. After DATA_W steps go to DONE.
  - DONE: StallE=0. EX/MEM loads quotient or remainder at the edge, then IDLE.
  - Total: StallE high for DATA_W+1 cycles; result in ALU_ResultM DATA_W+2 edges after issue.
- While StallE=1, the EX/MEM register loads a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, DivByZeroM=0. Data fields are don't-care but held.
- Latched divider operands are immune to later changes in forwarding.
- flush_E=1 has priority over everything:
  - EX/MEM loads a bubble.
  - BUSY or DONE returns to IDLE at the next edge; StallE drops the same cycle as the flush.
- valid_E=0: EX/MEM loads a bubble, PCSrcE=0, FSM does not start.

Test Plan:
- DATA_W=24: add, RD1=10, RD2=5, fwd 00 -> ALU_ResultM=15, RegWriteM=1 one edge later. Then ForwardA=01, ResultW=50 -> 55.
- divu 100/4 -> StallE high 25 cycles, bubbles in M during stall, then ALU_ResultM=25. remu 100/7 -> 2.
- divu 9/0 -> no stall, ALU_ResultM=0xFFFFFF, DivByZeroM=1. remu 9/0 -> 9.
- sub 10-10 with BranchE=1, PCE=100, Imm=8 -> PCSrcE=1, PCTargetE=108. Same case with flush_E=1 -> PCSrcE=0.
- divu start, flush_E at stall cycle 5 -> StallE=0 that cycle, M bubble, next add completes normally. Repeat with rst=0 at stall cycle 10 -> all outputs 0 immediately.
- DATA_W=16: add 0xFFFF+1 -> 0. mul 0x0100*0x0100 -> 0. slt -1<1 -> 1.
